// File: rtl/gmii_rx_ptp_ts.sv
// ---------------------------------------------------------------------------
// gmii_rx_ptp_ts
//   Passive tap on a GMII receive stream. Finds preamble/SFD, samples the
//   local PTP time at SFD and parses untagged or single-802.1Q-tagged frames
//   carrying EtherType 0x88F7. For each PTP frame a record
//   {timestamp, messageType, sequenceId, vlan} is queued in a small
//   first-word-fall-through FIFO with registered outputs. The GMII stream
//   itself is only observed, never modified.
//
// Ports
//   gmii_rx_clk    : GMII receive clock, sole clock
//   rst_n          : asynchronous active-low reset
//   gmii_rx_ctrl   : rx data valid
//   gmii_rx_d      : rx data byte
//   link_up        : PCS link status; low flushes the FIFO and idles parser
//   ts_in          : local PTP time
//   m_ts_*         : record output (valid/ready handshake)
//   drop_cnt       : records lost to FIFO full, saturating
//   frame_cnt      : PTP frames recognised, wrapping
// ---------------------------------------------------------------------------
module gmii_rx_ptp_ts #(
  parameter int TS_W         = 64,
  parameter int FIFO_DEPTH   = 4,
  parameter int MIN_PREAMBLE = 1
) (
  input  logic            gmii_rx_clk,
  input  logic            rst_n,
  input  logic            gmii_rx_ctrl,
  input  logic [7:0]      gmii_rx_d,
  input  logic            link_up,
  input  logic [TS_W-1:0] ts_in,
  output logic [TS_W-1:0] m_ts_tdata,
  output logic [3:0]      m_ts_msg_type,
  output logic [15:0]     m_ts_seq_id,
  output logic            m_ts_vlan,
  output logic            m_ts_valid,
  input  logic            m_ts_ready,
  output logic [7:0]      drop_cnt,
  output logic [15:0]     frame_cnt
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [3:0] MIN_PRE = 4'(MIN_PREAMBLE);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_PRE,
    ST_HDR,
    ST_PTP,
    ST_WAIT_END
  } state_e;

  typedef struct packed {
    logic [TS_W-1:0] ts;
    logic [3:0]      msg_type;
    logic [15:0]     seq_id;
    logic            vlan;
  } rec_t;

  // -------------------------------------------------------------------------
  // Parser state
  // -------------------------------------------------------------------------
  state_e          state_q, state_d;
  logic [3:0]      pre_cnt_q, pre_cnt_d;
  logic [6:0]      offset_q, offset_d;
  logic [TS_W-1:0] ts_q, ts_d;
  logic            vlan_q, vlan_d;
  logic [7:0]      hi_q, hi_d;        // high byte of EtherType / sequenceId
  logic [3:0]      msg_type_q, msg_type_d;
  logic [15:0]     frame_cnt_q, frame_cnt_d;
  logic            push;

  logic [6:0]      offset_inc;
  logic [6:0]      ptp_base;
  rec_t            push_rec;

  assign offset_inc = (offset_q == 7'd127) ? offset_q : offset_q + 7'd1;
  assign ptp_base   = vlan_q ? 7'd18 : 7'd14;
  assign push_rec   = '{ts: ts_q, msg_type: msg_type_q,
                        seq_id: {hi_q, gmii_rx_d}, vlan: vlan_q};

  always_comb begin
    // NOTE: every variable gets a default first so no path can infer a latch.
    state_d     = state_q;
    pre_cnt_d   = pre_cnt_q;
    offset_d    = offset_q;
    ts_d        = ts_q;
    vlan_d      = vlan_q;
    hi_d        = hi_q;
    msg_type_d  = msg_type_q;
    frame_cnt_d = frame_cnt_q;
    push        = 1'b0;

    if (!link_up) begin
      state_d = ST_IDLE;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (gmii_rx_ctrl) begin
            if (gmii_rx_d == 8'h55) begin
              pre_cnt_d = 4'd1;
              state_d   = ST_PRE;
            end else begin
              state_d = ST_WAIT_END;
            end
          end
        end

        ST_PRE: begin
          if (!gmii_rx_ctrl) begin
            state_d = ST_IDLE;
          end else if (gmii_rx_d == 8'h55) begin
            pre_cnt_d = (pre_cnt_q == 4'd15) ? pre_cnt_q : pre_cnt_q + 4'd1;
          end else if (gmii_rx_d == 8'hD5 && pre_cnt_q >= MIN_PRE) begin
            // Only reachable from IDLE, i.e. after the previous frame pushed
            // or aborted, so this never clobbers a timestamp still in use.
            ts_d     = ts_in;
            offset_d = 7'd0;
            vlan_d   = 1'b0;
            state_d  = ST_HDR;
          end else begin
            state_d = ST_WAIT_END;
          end
        end

        ST_HDR: begin
          if (!gmii_rx_ctrl) begin
            state_d = ST_IDLE;
          end else begin
            offset_d = offset_inc;
            if (offset_q == 7'd12 || offset_q == 7'd16) begin
              hi_d = gmii_rx_d;
            end
            if (offset_q == 7'd13) begin
              if ({hi_q, gmii_rx_d} == 16'h8100) begin
                vlan_d = 1'b1;
              end else if ({hi_q, gmii_rx_d} == 16'h88F7) begin
                state_d = ST_PTP;
              end else begin
                state_d = ST_WAIT_END;
              end
            end
            // Only still in HDR at offset 17 when a tag was seen at 12-13.
            if (offset_q == 7'd17) begin
              if ({hi_q, gmii_rx_d} == 16'h88F7) begin
                state_d = ST_PTP;
              end else begin
                state_d = ST_WAIT_END;
              end
            end
          end
        end

        ST_PTP: begin
          if (!gmii_rx_ctrl) begin
            state_d = ST_IDLE;
          end else begin
            offset_d = offset_inc;
            if (offset_q == ptp_base) begin
              msg_type_d = gmii_rx_d[3:0];
            end
            if (offset_q == ptp_base + 7'd30) begin
              hi_d = gmii_rx_d;
            end
            if (offset_q == ptp_base + 7'd31) begin
              push        = 1'b1;
              frame_cnt_d = frame_cnt_q + 16'd1;
              state_d     = ST_WAIT_END;
            end
          end
        end

        ST_WAIT_END: begin
          if (!gmii_rx_ctrl) begin
            state_d = ST_IDLE;
          end
        end

        default: state_d = ST_IDLE;
      endcase
    end
  end

  // -------------------------------------------------------------------------
  // Record FIFO: circular store plus a registered head copy on the outputs.
  // -------------------------------------------------------------------------
  rec_t             mem_q [FIFO_DEPTH];
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  rec_t             out_q, out_d;
  logic             valid_q, valid_d;
  logic [7:0]       drop_cnt_q, drop_cnt_d;
  logic             pop, full, wr_en;
  rec_t             head;

  assign pop  = valid_q & m_ts_ready;
  assign full = (count_q == CNT_W'(FIFO_DEPTH));

  always_comb begin
    wr_en      = 1'b0;
    rd_ptr_d   = rd_ptr_q;
    wr_ptr_d   = wr_ptr_q;
    count_d    = count_q;
    drop_cnt_d = drop_cnt_q;
    head       = mem_q[rd_ptr_q];
    out_d      = '0;
    valid_d    = 1'b0;

    if (!link_up) begin
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      count_d  = '0;
    end else begin
      // A pop frees a slot this same cycle, so push-while-full still lands.
      wr_en = push & (~full | pop);
      if (push && full && !pop && drop_cnt_q != 8'hFF) begin
        drop_cnt_d = drop_cnt_q + 8'd1;
      end
      if (pop) begin
        rd_ptr_d = rd_ptr_q + PTR_W'(1);
      end
      if (wr_en) begin
        wr_ptr_d = wr_ptr_q + PTR_W'(1);
      end
      count_d = count_q + CNT_W'(wr_en) - CNT_W'(pop);

      // Next head is either already stored or is the slot written now.
      if (wr_en && rd_ptr_d == wr_ptr_q) begin
        head = push_rec;
      end else begin
        head = mem_q[rd_ptr_d];
      end
      if (count_d != '0) begin
        out_d   = head;
        valid_d = 1'b1;
      end
    end
  end

  // NOTE: the record store carries no reset; valid is tracked by count_q, so
  // stale contents are never observed and the array needs no reset fan-out.
  always_ff @(posedge gmii_rx_clk) begin
    if (wr_en) begin
      mem_q[wr_ptr_q] <= push_rec;
    end
  end

  // NOTE: sequential state uses non-blocking assignments only, so every flop
  // samples its _d value from the same pre-edge snapshot.
  always_ff @(posedge gmii_rx_clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      pre_cnt_q   <= '0;
      offset_q    <= '0;
      ts_q        <= '0;
      vlan_q      <= 1'b0;
      hi_q        <= '0;
      msg_type_q  <= '0;
      frame_cnt_q <= '0;
      rd_ptr_q    <= '0;
      wr_ptr_q    <= '0;
      count_q     <= '0;
      out_q       <= '0;
      valid_q     <= 1'b0;
      drop_cnt_q  <= '0;
    end else begin
      state_q     <= state_d;
      pre_cnt_q   <= pre_cnt_d;
      offset_q    <= offset_d;
      ts_q        <= ts_d;
      vlan_q      <= vlan_d;
      hi_q        <= hi_d;
      msg_type_q  <= msg_type_d;
      frame_cnt_q <= frame_cnt_d;
      rd_ptr_q    <= rd_ptr_d;
      wr_ptr_q    <= wr_ptr_d;
      count_q     <= count_d;
      out_q       <= out_d;
      valid_q     <= valid_d;
      drop_cnt_q  <= drop_cnt_d;
    end
  end

  assign m_ts_tdata    = out_q.ts;
  assign m_ts_msg_type = out_q.msg_type;
  assign m_ts_seq_id   = out_q.seq_id;
  assign m_ts_vlan     = out_q.vlan;
  assign m_ts_valid    = valid_q;
  assign drop_cnt      = drop_cnt_q;
  assign frame_cnt     = frame_cnt_q;

endmodule
